wb_drain: RTL and testbench
===========================

WB_DRAIN -- requirements
Module: wb_drain

Interface
REQ-001 Parameter DEPTH, default 2, write-buffer entries; legal values are 2 only.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 in_valid  input  1  producer offers a retiring result this cycle.
REQ-005 in_ready  output  1  buffer accepts the offer; transfer = in_valid && in_ready.
REQ-006 in_wen  input  1  offered result writes a register; 0 = retire-only, no write.
REQ-007 in_regsel  input  3  destination register of the offered result.
REQ-008 in_data  input  16  value to write.
REQ-009 hold  input  1  register-file write port unavailable; suppresses drain.
REQ-010 flush  input  1  discard all buffered writes.
REQ-011 write  output  1  register-file write enable.
REQ-012 writeregsel  output  3  register-file write index.
REQ-013 writedata  output  16  register-file write value.
REQ-014 q1sel, q2sel  input  3 each  decode-stage source registers to check.
REQ-015 hazard1, hazard2  output  1 each  source has a buffered write not visible through the register-file bypass.
REQ-016 err  output  1  single-cycle protocol-violation pulse.

Function
REQ-017 Buffer: in-order FIFO, DEPTH entries of {regsel[2:0], data[15:0]}, count 0..2.
REQ-018 in_ready = (count < DEPTH); no combinational path from hold, flush or pop to in_ready.
REQ-019 Transfer with in_wen=1 and no flush pushes one entry; transfer with in_wen=0 is accepted and discarded.
REQ-020 pop = (count != 0) && !hold && !flush.
REQ-021 write = pop (combinational); writeregsel/writedata = head entry whenever count != 0, else 0.
REQ-022 Head advances on the edge after pop; throughput is one write per cycle.
REQ-023 Push and pop in the same cycle leave count unchanged; pushing when count=1 and popping lands the new entry at head.
REQ-024 Pointers are 1 bit and wrap 1 -> 0.
REQ-025 Scoreboard: per-register 2-bit pending count; +1 on push, -1 on pop, net 0 when both hit the same register.
REQ-026 hazardN = pend[qNsel] > ((pop && writeregsel == qNsel) ? 1 : 0); a write presented this cycle is covered by the register-file bypass and is not a hazard.
REQ-027 flush: on the next edge, count=0, pointers=0, all pending counts=0; the same-cycle transfer is accepted (in_ready unchanged) but not pushed; write=0 that cycle.
REQ-028 hold with count=DEPTH: in_ready=0, contents frozen, hazards still reported.
REQ-029 err pulses for one cycle after a cycle in which in_valid=1 and in_ready=0 is followed by in_valid=0 with no transfer (offer withdrawn); err is registered.
REQ-030 A pending counter never exceeds DEPTH and never underflows; reaching either condition is a design bug flagged by assertion.

Reset
REQ-031 rst=0 asynchronously clears count, pointers, pending counts, err and the withdrawal-tracking flag.
REQ-032 Outputs during and after reset until the first push: in_ready=1, write=0, writeregsel=0, writedata=0, hazard1=hazard2=0, err=0.
REQ-033 Reset mid-operation drops buffered writes with no write pulse; entry storage need not be reset.

Structure
REQ-034 DEPTH, register-index width (3) and data width (16) are shared constants in the processor package alongside the register-file widths.
REQ-035 The FIFO is one sub-module, wb_fifo (storage, pointers, count); the scoreboard and err logic live in wb_drain.
REQ-036 The outputs write, writeregsel and writedata connect directly to the register file's write, writeregsel and writedata inputs.

Verification
REQ-037 Push r3=0x1234, then query q1sel=3 in the next cycle -> write=1, writeregsel=3, writedata=0x1234, hazard1=0 (bypass-covered).
REQ-038 hold=1; push r2=0xAAAA, then r2=0xBBBB -> in_ready=0, hazard on r2=1; release hold -> 0xAAAA, then 0xBBBB on consecutive cycles, hazard=1 during the first write and 0 after.
REQ-039 count=2 with push and pop in the same cycle -> rejected push (in_ready=0), no loss, FIFO order kept over 20 random transfers.
REQ-040 Buffered writes to r5 and r6, assert flush -> no write pulses, all hazards 0 on the next cycle, in_ready=1.
REQ-041 in_valid=1 while full, then in_valid=0 -> err=1 for exactly one cycle; in_wen=0 transfers -> no write, no scoreboard change.
REQ-042 Assert rst mid-drain with count=2 -> outputs at reset values immediately; no write after release.

Source files
------------

// File: rtl/wb_drain_pkg.sv
// Shared widths and types for the writeback drain buffer and register file.
// Pure declarations; no logic.
package wb_drain_pkg;
    localparam int WB_DEPTH = 2;
    localparam int REG_W    = 3;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 1 << REG_W;
    localparam int CNT_W    = 2;

    typedef logic [REG_W-1:0]  regsel_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef struct packed {
        regsel_t regsel;
        data_t   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_drain_fifo.sv
// wb_fifo: two-entry in-order write buffer; head visible combinationally, 1-cycle push-to-head.
// Caller gates push/pop; flush wins over both and empties the buffer on the next edge.
module wb_fifo
    import wb_drain_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    input  logic      flush,
    output cnt_t      count,
    output wb_entry_t head
);
    wb_entry_t mem [DEPTH];
    logic      wr_ptr;
    logic      rd_ptr;

    // Entry storage is left unreset; the top masks head whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/wb_drain.sv
// Writeback drain: buffers retiring register writes, drains one per cycle, reports RAW hazards.
// in_ready depends only on buffer occupancy; hold/flush stall or discard the drain side.
module wb_drain
    import wb_drain_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [2:0]  in_regsel,
    input  logic [15:0] in_data,
    input  logic        hold,
    input  logic        flush,
    output logic        write,
    output logic [2:0]  writeregsel,
    output logic [15:0] writedata,
    input  logic [2:0]  q1sel,
    input  logic [2:0]  q2sel,
    output logic        hazard1,
    output logic        hazard2,
    output logic        err
);
    cnt_t      count;
    wb_entry_t head;
    logic      push;
    logic      pop;
    logic      blocked;

    logic [NUM_REGS-1:0][CNT_W-1:0] pend;
    logic [NUM_REGS-1:0][CNT_W-1:0] pend_nxt;
    logic [NUM_REGS-1:0]            inc_vec;
    logic [NUM_REGS-1:0]            dec_vec;
    logic                           sb_bug;

    assign in_ready = (count < cnt_t'(DEPTH));
    assign push     = in_valid && in_ready && in_wen && !flush;
    assign pop      = (count != '0) && !hold && !flush;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry ({in_regsel, in_data}),
        .pop        (pop),
        .flush      (flush),
        .count      (count),
        .head       (head)
    );

    assign write       = pop;
    assign writeregsel = (count != '0) ? head.regsel : '0;
    assign writedata   = (count != '0) ? head.data   : '0;

    // A write leaving the buffer this cycle is forwarded by the register-file bypass.
    assign hazard1 = pend[q1sel] > ((pop && (writeregsel == q1sel)) ? cnt_t'(1) : cnt_t'(0));
    assign hazard2 = pend[q2sel] > ((pop && (writeregsel == q2sel)) ? cnt_t'(1) : cnt_t'(0));

    always_comb begin
        pend_nxt = pend;
        inc_vec  = '0;
        dec_vec  = '0;
        sb_bug   = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_vec[i] = push && (in_regsel == regsel_t'(i));
            dec_vec[i] = pop && (writeregsel == regsel_t'(i));
            if (inc_vec[i] && !dec_vec[i]) begin
                pend_nxt[i] = pend[i] + cnt_t'(1);
                if (pend[i] >= cnt_t'(DEPTH)) begin
                    sb_bug = 1'b1;
                end
            end else if (dec_vec[i] && !inc_vec[i]) begin
                pend_nxt[i] = pend[i] - cnt_t'(1);
                if (pend[i] == '0) begin
                    sb_bug = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else if (flush) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // err fires one cycle after a refused offer is withdrawn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blocked <= 1'b0;
            err     <= 1'b0;
        end else begin
            blocked <= in_valid && !in_ready;
            err     <= blocked && !in_valid;
        end
    end

    a_pend_range: assert property (@(posedge clk) disable iff (!rst) !sb_bug);
endmodule

// File: tb/tb_wb_drain.sv
// Scenario bench for wb_drain: expected writes are queued at stimulus time and checked as they drain.
module tb_wb_drain;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_wen, hold, flush;
    logic [2:0]  in_regsel, q1sel, q2sel, writeregsel;
    logic [15:0] in_data, writedata;
    logic        write, hazard1, hazard2, err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [18:0] exp_q[$];
    logic [18:0] mon_exp;

    localparam logic [23:0] RESET_VEC = {1'b1, 1'b0, 3'd0, 16'd0, 3'b000};

    wb_drain dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
        .in_regsel(in_regsel), .in_data(in_data), .hold(hold), .flush(flush),
        .write(write), .writeregsel(writeregsel), .writedata(writedata),
        .q1sel(q1sel), .q2sel(q2sel), .hazard1(hazard1), .hazard2(hazard2), .err(err)
    );

    always #5 clk = ~clk;

    // Every drained write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && write === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: got r%0d=%h, required no write", writeregsel, writedata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({writeregsel, writedata} !== mon_exp) begin
                    n_bad++;
                    $display("FAIL wr_order: got r%0d=%h, required r%0d=%h",
                             writeregsel, writedata, mon_exp[18:16], mon_exp[15:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_wen = 1'b0; in_regsel = '0; in_data = '0;
        hold = 1'b0; flush = 1'b0;
    endtask

    task automatic offer(input logic wen, input logic [2:0] rs, input logic [15:0] d);
        in_valid = 1'b1; in_wen = wen; in_regsel = rs; in_data = d;
    endtask

    task automatic test_reset();
        logic [23:0] obs;
        rst = 1'b1; idle_inputs(); q1sel = '0; q2sel = '0;
        #1 rst = 1'b0;
        #2;
        obs = {in_ready, write, writeregsel, writedata, hazard1, hazard2, err};
        n_cmp++;
        if (obs !== RESET_VEC) begin n_bad++; $display("FAIL reset_during: got %h, required %h", obs, RESET_VEC); end
        step(); step();
        rst = 1'b1;
        #1;
        obs = {in_ready, write, writeregsel, writedata, hazard1, hazard2, err};
        n_cmp++;
        if (obs !== RESET_VEC) begin n_bad++; $display("FAIL reset_after: got %h, required %h", obs, RESET_VEC); end
    endtask

    task automatic test_bypass();
        step(); offer(1'b1, 3'd3, 16'h1234); q1sel = 3'd3; q2sel = 3'd3; #1;
        n_cmp++;
        if ({in_ready, hazard1} !== 2'b10) begin n_bad++; $display("FAIL byp_accept: got %b, required 10", {in_ready, hazard1}); end
        exp_q.push_back({3'd3, 16'h1234});
        step(); in_valid = 1'b0; #1;
        n_cmp++;
        if ({write, writeregsel, writedata, hazard1, hazard2} !== {1'b1, 3'd3, 16'h1234, 2'b00}) begin
            n_bad++;
            $display("FAIL byp_write: got %b r%0d=%h hz=%b%b, required 1 r3=1234 hz=00",
                     write, writeregsel, writedata, hazard1, hazard2);
        end
        step(); #1;
        n_cmp++;
        if ({write, hazard1} !== 2'b00) begin n_bad++; $display("FAIL byp_idle: got %b, required 00", {write, hazard1}); end
    endtask

    task automatic test_hold();
        step(); hold = 1'b1; offer(1'b1, 3'd2, 16'hAAAA); q1sel = 3'd2; q2sel = 3'd5; #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_push1: got ready=%b, required 1", in_ready); end
        exp_q.push_back({3'd2, 16'hAAAA});
        step(); offer(1'b1, 3'd2, 16'hBBBB); #1;
        n_cmp++;
        if ({in_ready, hazard1} !== 2'b11) begin n_bad++; $display("FAIL hold_push2: got %b, required 11", {in_ready, hazard1}); end
        exp_q.push_back({3'd2, 16'hBBBB});
        step(); in_valid = 1'b0; #1;
        n_cmp++;
        if ({in_ready, write, hazard1, hazard2} !== 4'b0010) begin
            n_bad++; $display("FAIL hold_full: got %b, required 0010", {in_ready, write, hazard1, hazard2});
        end
        step(); hold = 1'b0; #1;
        n_cmp++;
        if ({write, writedata, hazard1} !== {1'b1, 16'hAAAA, 1'b1}) begin
            n_bad++; $display("FAIL hold_drain1: got %b %h %b, required 1 aaaa 1", write, writedata, hazard1);
        end
        step(); #1;
        n_cmp++;
        if ({write, writedata, hazard1} !== {1'b1, 16'hBBBB, 1'b0}) begin
            n_bad++; $display("FAIL hold_drain2: got %b %h %b, required 1 bbbb 0", write, writedata, hazard1);
        end
        step(); #1;
        n_cmp++;
        if ({write, hazard1, in_ready} !== 3'b001) begin
            n_bad++; $display("FAIL hold_empty: got %b, required 001", {write, hazard1, in_ready});
        end
    endtask

    task automatic test_full_push_pop();
        int   mc;
        int   xf;
        logic ready_m, push_m, pop_m;
        step(); hold = 1'b1; offer(1'b1, 3'd1, 16'h0101); #1; exp_q.push_back({3'd1, 16'h0101});
        step(); offer(1'b1, 3'd4, 16'h0404); #1; exp_q.push_back({3'd4, 16'h0404});
        step(); hold = 1'b0; offer(1'b1, 3'd6, 16'h0606); #1;
        n_cmp++;
        if ({in_ready, write} !== 2'b01) begin n_bad++; $display("FAIL full_pushpop: got %b, required 01", {in_ready, write}); end
        mc = 1; xf = 0;
        for (int cyc = 0; cyc < 300 && xf < 20; cyc++) begin
            step();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_wen    = ($urandom_range(0, 3) != 0);
            in_regsel = 3'($urandom_range(0, 7));
            in_data   = 16'($urandom);
            hold      = ($urandom_range(0, 3) == 0);
            #1;
            ready_m = (mc < 2);
            n_cmp++;
            if (in_ready !== ready_m) begin n_bad++; $display("FAIL rand_ready: got %b, required %b", in_ready, ready_m); end
            push_m = in_valid && ready_m && in_wen;
            pop_m  = (mc != 0) && !hold;
            if (in_valid && ready_m) xf++;
            if (push_m) exp_q.push_back({in_regsel, in_data});
            if (push_m && !pop_m) mc++;
            else if (!push_m && pop_m) mc--;
        end
        n_cmp++;
        if (xf < 20) begin n_bad++; $display("FAIL rand_xfers: got %0d, required 20", xf); end
        for (int i = 0; i < 4; i++) begin
            step(); idle_inputs();
        end
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_lost: got %0d undrained, required 0", exp_q.size()); end
    endtask

    task automatic test_flush();
        step(); hold = 1'b1; offer(1'b1, 3'd5, 16'h5555); q1sel = 3'd5; q2sel = 3'd6; #1;
        exp_q.push_back({3'd5, 16'h5555});
        step(); offer(1'b1, 3'd6, 16'h6666); #1;
        exp_q.push_back({3'd6, 16'h6666});
        step(); in_valid = 1'b0; hold = 1'b0; flush = 1'b1; #1;
        n_cmp++;
        if ({write, in_ready, hazard1, hazard2} !== 4'b0011) begin
            n_bad++; $display("FAIL flush_cycle: got %b, required 0011", {write, in_ready, hazard1, hazard2});
        end
        step(); exp_q.delete(); offer(1'b1, 3'd7, 16'h7777); #1;
        n_cmp++;
        if ({in_ready, write, hazard1, hazard2} !== 4'b1000) begin
            n_bad++; $display("FAIL flush_after: got %b, required 1000", {in_ready, write, hazard1, hazard2});
        end
        step(); flush = 1'b0; in_valid = 1'b0; q1sel = 3'd7; #1;
        n_cmp++;
        if ({write, in_ready, hazard1} !== 3'b010) begin
            n_bad++; $display("FAIL flush_xfer_dropped: got %b, required 010", {write, in_ready, hazard1});
        end
        step(); #1;
        n_cmp++;
        if (write !== 1'b0) begin n_bad++; $display("FAIL flush_nowrite: got %b, required 0", write); end
    endtask

    task automatic test_err();
        step(); hold = 1'b1; offer(1'b1, 3'd1, 16'h0111); q1sel = 3'd0; q2sel = 3'd0; #1;
        exp_q.push_back({3'd1, 16'h0111});
        step(); offer(1'b1, 3'd4, 16'h0444); #1;
        exp_q.push_back({3'd4, 16'h0444});
        step(); offer(1'b1, 3'd7, 16'h0777); #1;
        n_cmp++;
        if ({in_ready, err} !== 2'b00) begin n_bad++; $display("FAIL err_blocked: got %b, required 00", {in_ready, err}); end
        step(); in_valid = 1'b0; #1;
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL err_early: got %b, required 0", err); end
        step(); #1;
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL err_pulse: got %b, required 1", err); end
        step(); #1;
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL err_width: got %b, required 0", err); end
        step(); hold = 1'b0; #1;
        step(); #1;
        step(); offer(1'b0, 3'd3, 16'hDEAD); q1sel = 3'd3; #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL nowen_ready: got %b, required 1", in_ready); end
        step(); offer(1'b0, 3'd3, 16'hBEEF); #1;
        n_cmp++;
        if ({write, hazard1, in_ready} !== 3'b001) begin
            n_bad++; $display("FAIL nowen_1: got %b, required 001", {write, hazard1, in_ready});
        end
        step(); in_valid = 1'b0; #1;
        n_cmp++;
        if ({write, hazard1, err} !== 3'b000) begin
            n_bad++; $display("FAIL nowen_2: got %b, required 000", {write, hazard1, err});
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] obs;
        int          wr_seen;
        step(); hold = 1'b1; offer(1'b1, 3'd1, 16'h1111); q1sel = 3'd1; q2sel = 3'd2; #1;
        exp_q.push_back({3'd1, 16'h1111});
        step(); offer(1'b1, 3'd2, 16'h2222); #1;
        exp_q.push_back({3'd2, 16'h2222});
        step(); in_valid = 1'b0; hold = 1'b0; rst = 1'b0; #1;
        exp_q.delete();
        obs = {in_ready, write, writeregsel, writedata, hazard1, hazard2, err};
        n_cmp++;
        if (obs !== RESET_VEC) begin n_bad++; $display("FAIL rstmid_outputs: got %h, required %h", obs, RESET_VEC); end
        step(); step(); rst = 1'b1;
        wr_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            if (write === 1'b1) wr_seen++;
        end
        n_cmp++;
        if (wr_seen != 0) begin n_bad++; $display("FAIL rstmid_writes: got %0d, required 0", wr_seen); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_hold();
        test_full_push_pop();
        test_flush();
        test_err();
        test_reset_mid();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
